// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus types and DMA controller state encoding.
package cpu_bus_pkg;

    typedef logic [15:0] cpu_addr_t;
    typedef logic [7:0]  cpu_data_t;

    localparam cpu_addr_t DmaRegAddrDefault  = 16'h4014;
    localparam cpu_addr_t OamDataAddrDefault = 16'h2004;

    typedef enum logic [2:0] {
        StIdle,
        StHaltWait,
        StAlign,
        StRead,
        StWrite
    } dma_state_t;

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational select between the CPU bus and the DMA engine's read/write cycles.
module oam_dma_bus_mux
    import cpu_bus_pkg::*;
#(
    parameter cpu_addr_t OAM_DATA_ADDR = OamDataAddrDefault
) (
    input  dma_state_t state_i,
    input  logic       dma_owner_i,
    input  cpu_addr_t  cpu_addr_i,
    input  cpu_data_t  cpu_data_i,
    input  logic       cpu_we_i,
    input  cpu_data_t  page_i,
    input  cpu_data_t  idx_i,
    input  cpu_data_t  data_i,
    output cpu_addr_t  bus_addr_o,
    output cpu_data_t  bus_data_o,
    output logic       bus_we_o
);

    always_comb begin
        bus_addr_o = cpu_addr_i;
        bus_data_o = cpu_data_i;
        bus_we_o   = cpu_we_i;
        if (dma_owner_i) begin
            bus_we_o   = 1'b0;
            bus_data_o = data_i;
            case (state_i)
                StRead: bus_addr_o = {page_i, idx_i};
                StWrite: begin
                    bus_addr_o = OAM_DATA_ADDR;
                    bus_we_o   = 1'b1;
                end
                // Alignment dummy cycle keeps the CPU's address on a read strobe.
                default: bus_addr_o = cpu_addr_i;
            endcase
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: halts the CPU, copies one 256-byte page to the OAM data port,
// then hands the bus back.
module oam_dma_ctrl
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DmaRegAddrDefault,
    parameter logic [15:0] OAM_DATA_ADDR = OamDataAddrDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  bus_data_i,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_we_o,
    output logic        rdy_o,
    output logic        busy_o,
    output logic        dma_owner_o,
    output logic        done_o
);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       phase_q, phase_d;

    logic dma_reg_wr;
    assign dma_reg_wr = cpu_we_i && (cpu_addr_i == DMA_REG_ADDR);

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        idx_d       = idx_q;
        data_d      = data_q;
        phase_d     = ~phase_q;
        rdy_o       = 1'b0;
        dma_owner_o = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                rdy_o = 1'b1;
                if (dma_reg_wr) begin
                    page_d  = cpu_data_i;
                    idx_d   = 8'h00;
                    state_d = StHaltWait;
                end
            end
            StHaltWait: begin
                // The CPU only stops on a read; writes keep flowing and may re-trigger.
                if (cpu_we_i) begin
                    if (dma_reg_wr) begin
                        page_d = cpu_data_i;
                    end
                end else begin
                    state_d = phase_q ? StRead : StAlign;
                end
            end
            StAlign: begin
                dma_owner_o = 1'b1;
                state_d     = StRead;
            end
            StRead: begin
                dma_owner_o = 1'b1;
                data_d      = bus_data_i;
                state_d     = StWrite;
            end
            StWrite: begin
                dma_owner_o = 1'b1;
                if (idx_q == 8'hFF) begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_o = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            phase_q <= phase_d;
        end
    end

    oam_dma_bus_mux #(
        .OAM_DATA_ADDR (OAM_DATA_ADDR)
    ) u_bus_mux (
        .state_i     (state_q),
        .dma_owner_i (dma_owner_o),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_we_i    (cpu_we_i),
        .page_i      (page_q),
        .idx_i       (idx_q),
        .data_i      (data_q),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_we_o    (bus_we_o)
    );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a behavioural memory answers bus reads, a monitor
// checks every OAM write against queued expectations.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_we_i;
    logic [7:0]  bus_data_i;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_data_o;
    logic        bus_we_o;
    logic        rdy_o;
    logic        busy_o;
    logic        dma_owner_o;
    logic        done_o;

    logic [7:0]  mem [0:65535];
    logic        tb_phase;
    logic [15:0] prev_addr;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [15:0] raddr;
        logic [7:0]  data;
        logic        done;
    } exp_t;
    exp_t q[$];

    oam_dma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_we_i    (cpu_we_i),
        .bus_data_i  (bus_data_i),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_we_o    (bus_we_o),
        .rdy_o       (rdy_o),
        .busy_o      (busy_o),
        .dma_owner_o (dma_owner_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    assign bus_data_i = mem[bus_addr_o];

    always @(posedge clk) begin
        if (bus_we_o === 1'b1) mem[bus_addr_o] <= bus_data_o;
        tb_phase <= rst ? 1'b0 : ~tb_phase;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [7:0] page, input logic [7:0] n);
        return (page == 8'hFF) ? ~n : (n ^ 8'hA5);
    endfunction

    // Monitor: every OAM write pops one expectation; read address is the previous cycle's.
    always @(negedge clk) begin
        exp_t e;
        if (dma_owner_o === 1'b1) check("no_addr_zero", 32'(bus_addr_o != 16'h0000), 32'd1);
        if (dma_owner_o === 1'b1 && bus_we_o === 1'b1 && bus_addr_o == 16'h2004) begin
            if (q.size() == 0) begin
                check("unexpected_oam_write", 32'(bus_data_o), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("read_addr", 32'(prev_addr), 32'(e.raddr));
                check("oam_data", 32'(bus_data_o), 32'(e.data));
                check("done_pulse", 32'(done_o), 32'(e.done));
            end
        end else if (done_o === 1'b1) begin
            check("stray_done", 32'(done_o), 32'd0);
        end
        prev_addr = bus_addr_o;
    end

    task automatic do_transfer(input logic [7:0] page, input logic hp_want, input int extra,
                               input int abort_at);
        int   owned;
        int   wcount;
        bit   seen;
        logic hp;
        exp_t e;
        // Trigger phase chosen so the halt cycle lands on the requested phase.
        logic want_t;
        want_t = hp_want ^ extra[0] ^ 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (tb_phase == want_t) break;
        end
        for (int n = 0; n < 256; n++) begin
            e.raddr = {page, n[7:0]};
            e.data  = exp_data(page, n[7:0]);
            e.done  = (n == 255);
            q.push_back(e);
        end
        cpu_addr_i = 16'h4014; cpu_data_i = page; cpu_we_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < extra; k++) begin
            cpu_addr_i = 16'h0300 + 16'(k);
            cpu_data_i = 8'h11 * 8'(k + 1);
            cpu_we_i   = 1'b1;
            @(negedge clk);
            check("hw_rdy_low", 32'(rdy_o), 32'd0);
            check("hw_not_owner", 32'(dma_owner_o), 32'd0);
            check("hw_pass_addr", 32'(bus_addr_o), 32'(cpu_addr_i));
            check("hw_pass_we", 32'(bus_we_o), 32'd1);
            @(posedge clk); #1;
        end
        cpu_addr_i = 16'h8000; cpu_data_i = 8'h00; cpu_we_i = 1'b0;
        hp = tb_phase;
        @(negedge clk);
        check("halt_rdy", 32'(rdy_o), 32'd0);
        check("halt_busy", 32'(busy_o), 32'd1);
        check("halt_owner", 32'(dma_owner_o), 32'd0);
        owned = 0; wcount = 0; seen = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (dma_owner_o === 1'b1) owned++;
            if (dma_owner_o === 1'b1 && bus_we_o === 1'b1 && bus_addr_o == 16'h2004) wcount++;
            if (abort_at >= 0 && wcount == abort_at + 1) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                q.delete();
                @(negedge clk);
                check("abort_rdy", 32'(rdy_o), 32'd1);
                check("abort_busy", 32'(busy_o), 32'd0);
                check("abort_owner", 32'(dma_owner_o), 32'd0);
                repeat (4) @(negedge clk);
                return;
            end
            if (done_o === 1'b1) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("owned_cycles", 32'(owned), hp ? 32'd512 : 32'd513);
            check("write_count", 32'(wcount), 32'd256);
        end
        @(negedge clk);
        check("after_rdy", 32'(rdy_o), 32'd1);
        check("after_busy", 32'(busy_o), 32'd0);
        check("after_owner", 32'(dma_owner_o), 32'd0);
        check("after_pass_addr", 32'(bus_addr_o), 32'h8000);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        for (int n = 0; n < 256; n++) begin
            mem[16'h0200 + 16'(n)] = 8'(n) ^ 8'hA5;
            mem[16'hFF00 + 16'(n)] = ~8'(n);
        end

        cpu_addr_i = 16'h0123; cpu_data_i = 8'h5A; cpu_we_i = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_addr", 32'(bus_addr_o), 32'h0123);
            check("rst_data", 32'(bus_data_o), 32'h5A);
            check("rst_we", 32'(bus_we_o), 32'd1);
            check("rst_rdy", 32'(rdy_o), 32'd1);
            check("rst_busy", 32'(busy_o), 32'd0);
            check("rst_done", 32'(done_o), 32'd0);
            check("rst_owner", 32'(dma_owner_o), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_addr_i = 16'h8000; cpu_data_i = 8'h00; cpu_we_i = 1'b0;

        // Write to the neighbouring register must not start a transfer.
        @(posedge clk); #1;
        cpu_addr_i = 16'h4015; cpu_data_i = 8'h02; cpu_we_i = 1'b1;
        @(posedge clk); #1;
        cpu_addr_i = 16'h8000; cpu_we_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("nontrig_rdy", 32'(rdy_o), 32'd1);
            check("nontrig_busy", 32'(busy_o), 32'd0);
        end

        do_transfer(8'h02, 1'b0, 0, -1);
        do_transfer(8'h02, 1'b1, 0, -1);
        do_transfer(8'h02, 1'b1, 2, -1);
        check("cpu_write_0300", 32'(mem[16'h0300]), 32'h11);
        check("cpu_write_0301", 32'(mem[16'h0301]), 32'h22);
        do_transfer(8'h02, 1'b0, 0, 8'h40);
        do_transfer(8'h02, 1'b1, 0, -1);
        do_transfer(8'hFF, 1'b0, 0, -1);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
